card_dealer: RTL

CARD_DEALER -- requirements
Module: card_dealer

---
 rtl/blackjack_pkg.sv | 27 ++
 rtl/card_decode.sv | 34 +++
 rtl/card_dealer.sv | 104 ++++++++++
 3 files changed

// File: rtl/blackjack_pkg.sv
// rtl/blackjack_pkg.sv - shared card types, deck constants and dealer state encoding
package blackjack_pkg;

  localparam int DECK_SIZE = 52;
  localparam int RANKS     = 13;

  // Galois right-shift tap mask for x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DEAL = 2'd2
  } dealer_state_e;

  typedef struct packed {
    logic [3:0] rank;
    logic [1:0] suit;
    logic [3:0] points;
    logic       ace;
  } card_t;

  function automatic logic [3:0] rank_points(input logic [3:0] rank);
    return (rank > 4'd10) ? 4'd10 : rank;
  endfunction

endpackage

// File: rtl/card_decode.sv
// rtl/card_decode.sv - combinational map from shoe index 0..51 to rank, suit and blackjack value
module card_decode
  import blackjack_pkg::*;
(
  input  logic [5:0] idx_i,
  output card_t      card_o
);

  logic [1:0] suit;
  logic [5:0] suit_base;
  logic [3:0] rank;

  always_comb begin
    suit      = 2'd0;
    suit_base = 6'd0;
    if (idx_i >= 6'(3 * RANKS)) begin
      suit      = 2'd3;
      suit_base = 6'(3 * RANKS);
    end else if (idx_i >= 6'(2 * RANKS)) begin
      suit      = 2'd2;
      suit_base = 6'(2 * RANKS);
    end else if (idx_i >= 6'(RANKS)) begin
      suit      = 2'd1;
      suit_base = 6'(RANKS);
    end
    rank = 4'(idx_i - suit_base) + 4'd1;

    card_o.rank   = rank;
    card_o.suit   = suit;
    card_o.points = rank_points(rank);
    card_o.ace    = (rank == 4'd1);
  end

endmodule

// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - random-without-replacement card dealer driven by a free-running LFSR
module card_dealer #(
  parameter int          DECK_SIZE = blackjack_pkg::DECK_SIZE,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       card_req,
  input  logic       shuffle,
  output logic       card_valid,
  output logic [3:0] card_rank,
  output logic [1:0] card_suit,
  output logic [3:0] card_points,
  output logic       card_ace,
  output logic       busy,
  output logic [5:0] cards_left,
  output logic       deck_empty,
  output logic       empty_err
);

  import blackjack_pkg::*;

  localparam logic [5:0] DECK_CNT = 6'(DECK_SIZE);
  localparam logic [5:0] LAST_IDX = 6'(DECK_SIZE - 1);

  dealer_state_e        state_q;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [DECK_SIZE-1:0] used_q;
  logic [5:0]           idx_q;
  logic [5:0]           start_idx;
  logic [5:0]           cards_left_q;
  card_t                card_q;
  card_t                dec_card;
  logic                 card_valid_q;
  logic                 empty_err_q;

  assign lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  assign start_idx = (lfsr_q[5:0] >= DECK_CNT) ? (lfsr_q[5:0] - DECK_CNT) : lfsr_q[5:0];

  card_decode u_decode (
    .idx_i  (idx_q),
    .card_o (dec_card)
  );

  // shuffle overrides whatever the FSM would otherwise do this cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      lfsr_q       <= LFSR_SEED;
      used_q       <= '0;
      idx_q        <= '0;
      cards_left_q <= DECK_CNT;
      card_q       <= '0;
      card_valid_q <= 1'b0;
      empty_err_q  <= 1'b0;
    end else begin
      lfsr_q       <= lfsr_d;
      card_valid_q <= 1'b0;
      empty_err_q  <= 1'b0;
      if (shuffle) begin
        state_q      <= IDLE;
        used_q       <= '0;
        cards_left_q <= DECK_CNT;
      end else begin
        case (state_q)
          IDLE: begin
            if (card_req) begin
              if (cards_left_q != 6'd0) begin
                idx_q   <= start_idx;
                state_q <= SCAN;
              end else begin
                empty_err_q <= 1'b1;
              end
            end
          end
          SCAN: begin
            if (used_q[idx_q]) begin
              idx_q <= (idx_q == LAST_IDX) ? 6'd0 : idx_q + 6'd1;
            end else begin
              used_q[idx_q] <= 1'b1;
              card_q        <= dec_card;
              cards_left_q  <= cards_left_q - 6'd1;
              card_valid_q  <= 1'b1;
              state_q       <= DEAL;
            end
          end
          DEAL:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign card_valid  = card_valid_q;
  assign card_rank   = card_q.rank;
  assign card_suit   = card_q.suit;
  assign card_points = card_q.points;
  assign card_ace    = card_q.ace;
  assign busy        = (state_q != IDLE);
  assign cards_left  = cards_left_q;
  assign deck_empty  = (cards_left_q == 6'd0);
  assign empty_err   = empty_err_q;

endmodule
